led_run_arbiter: RTL and testbench
==================================

// Module: led_run_arbiter
// PURPOSE
//  Shares one tick-paced LED run counter between NUM_REQ requesters.
//  A run counts the counter 0..MAX_COUNT, one step per tick, then signals done.
//  Requests are granted round-robin, one run at a time, with abort on request drop.
//  Sits between the board request inputs and the LED bank; replaces per-user go/done FSMs.
// PARAMETERS
//  NUM_REQ    4        number of requesters (2..8)
//  TICK_DIV   1500000  clk cycles per counter step (1..2^24)
//  CNT_W      4        LED counter width
//  MAX_COUNT  15       final count of a run (< 2^CNT_W)
// PORTS
//  clk         in   1            system clock, single clock domain
//  rst_button  in   1            reset, asynchronous, active-low
//  req         in   NUM_REQ      level request per requester, held until done or abort
//  grant       out  NUM_REQ      one-hot owner of the counter, all-zero when idle
//  owner       out  $clog2(NUM_REQ)  index of current/last granted requester
//  led         out  CNT_W        shared run counter value
//  done        out  NUM_REQ      one-clk pulse to owner on run completion
//  busy        out  1            high while a run is in progress
// BEHAVIOUR
//  - Reset (rst_button=0, async): state=IDLE, grant=0, owner=0, led=0, done=0, busy=0,
//    rr pointer=0, tick divider=0. All outputs are registered.
//  - Tick: free-running divider counts 0..TICK_DIV-1 from reset; tick=1 for one clk
//    when count==TICK_DIV-1, then wraps to 0. Never restarted by grants.
//  - States: IDLE, COUNT, DONE.
//  - IDLE: if req!=0, pick first set bit searching ptr, ptr+1, .. mod NUM_REQ.
//    Next clk: state=COUNT, grant=onehot(sel), owner=sel, busy=1, led=0.
//    req=0: remain IDLE, outputs unchanged except done=0.
//  - COUNT, priority order:
//    1) req[owner]==0 (abort): next clk state=IDLE, grant=0, busy=0, led=0,
//       no done pulse, ptr=owner+1 mod NUM_REQ.
//    2) tick && led==MAX_COUNT: next clk state=DONE.
//    3) tick: led<=led+1.  No tick: led holds.
//  - DONE: exactly one clk. done[owner]=1 in this cycle only; grant still
//    asserted. Next clk: state=IDLE, grant=0, busy=0, led=0, done=0,
//    ptr=owner+1 mod NUM_REQ.
//  - First grant latency: 1 clk after req seen in IDLE. Back-to-back runs: new
//    grant 1 clk after leaving DONE (DONE->IDLE->COUNT), so 2 clks gap.
//  - Run length: MAX_COUNT+1 ticks in COUNT; first tick can be 1..TICK_DIV clks
//    after grant (divider not synced).
//  - Changes to req bits other than owner during COUNT/DONE are ignored.
//  - Abort and final tick in same clk: abort wins, no done.
//  - led never exceeds MAX_COUNT; no wrap.
//  - Illegal state encoding: return to IDLE with IDLE output values.
//  - Reset mid-run: immediate clear, no done pulse, ptr=0.
// STRUCTURE
//  - Shared package led_ctrl_pkg: state encodings (IDLE/COUNT/DONE),
//    default TICK_DIV and MAX_COUNT constants, used by this block and later
//    LED controllers.
//  - Sub-module tick_gen (TICK_DIV param; clk, rst_button -> tick): the divider.
//  - Top: rr select function, FSM, led counter, output regs.
//  - No derived clocks; tick is a clock enable only.
// TESTING  (TICK_DIV=4, MAX_COUNT=15, NUM_REQ=4 unless stated)
//  1. rst_button=0 with req=4'b1111 -> grant=0, led=0, done=0, busy=0, owner=0.
//  2. req=4'b0100 held -> grant=4'b0100 one clk later; led steps every 4 clks
//     to 15; done=4'b0100 for 1 clk after the 16th tick; then grant=0, led=0.
//  3. req=4'b1111 held after reset -> grants in order 0,1,2,3,0; each run has a
//     matching done pulse; 2-clk gap between runs.
//  4. Run for req[1]; drop req[1] at led=5 -> grant=0 next clk, led=0, no done;
//     next run with req=4'b0011 goes to 0 (ptr=2 wraps to 0).
//  5. Assert rst_button=0 mid-run at led=9 -> outputs clear at once, no done;
//     after release, req=4'b1000 -> owner=3 (ptr=0).
//  6. Drop req[owner] in the same clk as the final tick (led=15) ->
//     abort taken, done stays 0, ptr advances.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller family: FSM state encodings
// and the default pacing/length constants for a counter run.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } led_state_e;

  localparam int DEF_TICK_DIV  = 1500000;
  localparam int DEF_MAX_COUNT = 15;

endpackage

// File: rtl/led_run_arbiter_if.sv
// Request/grant bundle between the board requesters and the run arbiter.
// The arbiter sits on the slave side; the requester side drives req only.
interface led_run_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [OWN_W-1:0]   owner;
  logic [CNT_W-1:0]   led;
  logic [NUM_REQ-1:0] done;
  logic               busy;

  modport master (output req, input grant, owner, led, done, busy);
  modport slave  (input req, output grant, owner, led, done, busy);
endinterface

// File: rtl/led_run_arbiter_tick_gen.sv
// Free-running step divider: one-clk tick every TICK_DIV clocks, counted
// from reset and never restarted by arbitration activity.
import led_ctrl_pkg::*;

module tick_gen #(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_button,
  output logic tick
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Count 0..TICK_DIV-1 and wrap; the last count value is the tick cycle.
  always_ff @(posedge clk or negedge rst_button) begin
    if (!rst_button)        div_q <= '0;
    else if (div_q == LAST) div_q <= '0;
    else                    div_q <= div_q + DIV_W'(1);
  end

  assign tick = (div_q == LAST);
endmodule

// File: rtl/led_run_arbiter.sv
// Round-robin arbiter that lends one tick-paced LED run counter to one
// requester at a time, with abort when the owner drops its request.
import led_ctrl_pkg::*;

module led_run_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input logic              clk,
  input logic              rst_button,
  led_run_arbiter_if.slave bus
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] LED_MAX = CNT_W'(MAX_COUNT);

  led_state_e         state_q, state_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [OWN_W-1:0]   owner_q, owner_n;
  logic [CNT_W-1:0]   led_q, led_n;
  logic [NUM_REQ-1:0] done_q, done_n;
  logic               busy_q, busy_n;
  logic [OWN_W-1:0]   ptr_q, ptr_n;
  logic [OWN_W-1:0]   sel;
  logic               tick;

  // First set request bit searching upward from the pointer, wrapping.
  function automatic logic [OWN_W-1:0] rr_select(input logic [NUM_REQ-1:0] r,
                                                 input logic [OWN_W-1:0] p);
    logic [OWN_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!found && r[idx]) begin
        pick  = OWN_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Requester after the given one, wrapping at NUM_REQ.
  function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] o);
    return OWN_W'((int'(o) + 1) % NUM_REQ);
  endfunction

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk        (clk),
    .rst_button (rst_button),
    .tick       (tick)
  );

  assign sel = rr_select(bus.req, ptr_q);

  // Next-state and next-output decode; abort outranks the final tick.
  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    owner_n = owner_q;
    led_n   = led_q;
    done_n  = '0;
    busy_n  = busy_q;
    ptr_n   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_n      = ST_COUNT;
          grant_n      = '0;
          grant_n[sel] = 1'b1;
          owner_n      = sel;
          busy_n       = 1'b1;
          led_n        = '0;
        end
      end
      ST_COUNT: begin
        if (!bus.req[owner_q]) begin
          state_n = ST_IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
          led_n   = '0;
          ptr_n   = next_idx(owner_q);
        end else if (tick && (led_q == LED_MAX)) begin
          state_n          = ST_DONE;
          done_n[owner_q]  = 1'b1;
        end else if (tick) begin
          led_n = led_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
        led_n   = '0;
        ptr_n   = next_idx(owner_q);
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
        led_n   = '0;
      end
    endcase
  end

  // State and output registers; reset clears a run without any done pulse.
  always_ff @(posedge clk or negedge rst_button) begin
    if (!rst_button) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      led_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      owner_q <= owner_n;
      led_q   <= led_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      ptr_q   <= ptr_n;
    end
  end

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.led   = led_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_led_run_arbiter.sv
// Directed bench for led_run_arbiter with TICK_DIV=4, MAX_COUNT=15, NUM_REQ=4.
// After reset release the divider ticks into edges 4, 8, 12, ... so a run
// granted on edge 1 reaches led=15 after edge 60 and pulses done after edge 64.
module tb_led_run_arbiter;
  logic clk = 1'b0;
  logic rst_button = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  led_run_arbiter_if #(.NUM_REQ(4), .CNT_W(4)) bus ();

  led_run_arbiter #(
    .NUM_REQ   (4),
    .TICK_DIV  (4),
    .CNT_W     (4),
    .MAX_COUNT (15)
  ) dut (
    .clk        (clk),
    .rst_button (rst_button),
    .bus        (bus)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic [3:0] l, input logic [3:0] d, input logic b);
    check_value({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check_value({tag, ".owner"}, 32'(bus.owner), 32'(o));
    check_value({tag, ".led"},   32'(bus.led),   32'(l));
    check_value({tag, ".done"},  32'(bus.done),  32'(d));
    check_value({tag, ".busy"},  32'(bus.busy),  32'(b));
  endtask

  task automatic step_clk(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_button = 1'b0;
    step_clk(2);
  endtask

  task automatic wait_done(input int max_cyc, output int cnt);
    cnt = max_cyc + 1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (bus.done != 4'b0000) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    bus.req = 4'b0000;

    // Reset with every request high: everything stays cleared.
    bus.req = 4'b1111;
    hold_reset();
    check_bus("rst", 4'b0000, 2'd0, 4'd0, 4'b0000, 1'b0);

    // Single requester 2: full run to done, then release.
    bus.req = 4'b0100;
    rst_button = 1'b1;
    step_clk(1);
    check_bus("run2.grant", 4'b0100, 2'd2, 4'd0, 4'b0000, 1'b1);
    step_clk(2);
    check_value("run2.led_e3", 32'(bus.led), 32'd0);
    step_clk(1);
    check_value("run2.led_e4", 32'(bus.led), 32'd1);
    step_clk(56);
    check_bus("run2.led15", 4'b0100, 2'd2, 4'd15, 4'b0000, 1'b1);
    step_clk(3);
    check_value("run2.pre_done", 32'(bus.done), 32'd0);
    step_clk(1);
    check_bus("run2.done", 4'b0100, 2'd2, 4'd15, 4'b0100, 1'b1);
    bus.req = 4'b0000;
    step_clk(1);
    check_bus("run2.idle", 4'b0000, 2'd2, 4'd0, 4'b0000, 1'b0);

    // All requesting: round-robin 0,1,2,3,0 with a 2-clk gap between runs.
    hold_reset();
    bus.req = 4'b1111;
    rst_button = 1'b1;
    step_clk(1);
    check_bus("rr.g0", 4'b0001, 2'd0, 4'd0, 4'b0000, 1'b1);
    wait_done(100, n);
    check_value("rr.wait0", 32'(n), 32'd63);
    check_value("rr.done0", 32'(bus.done), 32'b0001);
    step_clk(1);
    check_bus("rr.gap", 4'b0000, 2'd0, 4'd0, 4'b0000, 1'b0);
    step_clk(1);
    check_bus("rr.g1", 4'b0010, 2'd1, 4'd0, 4'b0000, 1'b1);
    wait_done(100, n);
    check_value("rr.wait1", 32'(n), 32'd62);
    check_value("rr.done1", 32'(bus.done), 32'b0010);
    step_clk(2);
    check_bus("rr.g2", 4'b0100, 2'd2, 4'd0, 4'b0000, 1'b1);
    wait_done(100, n);
    check_value("rr.wait2", 32'(n), 32'd62);
    check_value("rr.done2", 32'(bus.done), 32'b0100);
    step_clk(2);
    check_bus("rr.g3", 4'b1000, 2'd3, 4'd0, 4'b0000, 1'b1);
    wait_done(100, n);
    check_value("rr.wait3", 32'(n), 32'd62);
    check_value("rr.done3", 32'(bus.done), 32'b1000);
    step_clk(2);
    check_bus("rr.g4", 4'b0001, 2'd0, 4'd0, 4'b0000, 1'b1);

    // Abort: requester 1 drops at led=5; pointer 2 wraps to requester 0.
    hold_reset();
    bus.req = 4'b0010;
    rst_button = 1'b1;
    step_clk(1);
    check_bus("abort.grant", 4'b0010, 2'd1, 4'd0, 4'b0000, 1'b1);
    step_clk(19);
    check_value("abort.led5", 32'(bus.led), 32'd5);
    bus.req = 4'b0000;
    step_clk(1);
    check_bus("abort.idle", 4'b0000, 2'd1, 4'd0, 4'b0000, 1'b0);
    bus.req = 4'b0011;
    step_clk(1);
    check_bus("abort.next", 4'b0001, 2'd0, 4'd0, 4'b0000, 1'b1);

    // Reset in the middle of a run clears at once; pointer restarts at 0.
    hold_reset();
    bus.req = 4'b0001;
    rst_button = 1'b1;
    step_clk(36);
    check_bus("midrst.led9", 4'b0001, 2'd0, 4'd9, 4'b0000, 1'b1);
    rst_button = 1'b0;
    #1;
    check_bus("midrst.clear", 4'b0000, 2'd0, 4'd0, 4'b0000, 1'b0);
    step_clk(2);
    bus.req = 4'b1000;
    rst_button = 1'b1;
    step_clk(1);
    check_bus("midrst.next", 4'b1000, 2'd3, 4'd0, 4'b0000, 1'b1);

    // Abort coinciding with the final tick: no done, pointer moves to 3.
    hold_reset();
    bus.req = 4'b0100;
    rst_button = 1'b1;
    step_clk(63);
    check_bus("last.led15", 4'b0100, 2'd2, 4'd15, 4'b0000, 1'b1);
    bus.req = 4'b0000;
    step_clk(1);
    check_bus("last.abort", 4'b0000, 2'd2, 4'd0, 4'b0000, 1'b0);
    bus.req = 4'b1101;
    step_clk(1);
    check_bus("last.next", 4'b1000, 2'd3, 4'd0, 4'b0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
